bus_master_interface: RTL and testbench

BUS_MASTER_INTERFACE -- requirements
Module: bus_master_interface

---
 rtl/bus_master_interface.sv | 184 ++++++++++++++++++
 tb/tb_bus_master_interface.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_interface.sv
// Single-outstanding bus master: turns one request into a strobed bus cycle.
// It checks alignment, sign-extends reads, waits for write release and aborts on timeout.
module bus_master_interface #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   output logic        resp_valid,
   output logic        resp_error,
   output logic [31:0] resp_rdata,
   output logic [31:0] addr_bus,
   inout  wire  [31:0] data_bus,
   output logic        rd_bus,
   output logic        wr_bus,
   output logic [3:0]  data_mask_bus,
   input  logic        fc_bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_READ    = 3'd1,
      S_WRITE   = 3'd2,
      S_RELEASE = 3'd3,
      S_RESP    = 3'd4
   } state_e;

   state_e           state_q;
   logic [31:0]      addr_q, wdata_q, rdata_q;
   logic [1:0]       size_q;
   logic             signed_q, err_q, ready_q;
   logic             rd_q, wr_q, oe_q, valid_q, error_q;
   logic [3:0]       mask_q;
   logic [CNT_W-1:0] cnt_q;

   logic             fc_hi_c, bad_c, timeout_c;
   logic [3:0]       mask_c;
   logic [31:0]      rdext_c;

   // A floating or unknown completion line must never look like a completion.
   always_comb begin
      fc_hi_c   = (fc_bus === 1'b1);
      timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      bad_c     = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
      case (req_size)
         2'b00:   mask_c = 4'b0001;
         2'b01:   mask_c = 4'b0011;
         2'b10:   mask_c = 4'b1111;
         default: mask_c = 4'b0000;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00:   rdext_c = {{24{signed_q & data_bus[7]}}, data_bus[7:0]};
         2'b01:   rdext_c = {{16{signed_q & data_bus[15]}}, data_bus[15:0]};
         default: rdext_c = data_bus;
      endcase
   end

   // Bad requests still spend one cycle in READ/WRITE with strobes suppressed,
   // so their response lands at the same latency as a fast read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ready_q  <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         size_q   <= '0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         oe_q     <= 1'b0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         mask_q   <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  size_q   <= req_size;
                  signed_q <= req_signed;
                  err_q    <= bad_c;
                  mask_q   <= mask_c;
                  cnt_q    <= '0;
                  ready_q  <= 1'b0;
                  rd_q     <= !req_write && !bad_c;
                  wr_q     <= req_write && !bad_c;
                  oe_q     <= req_write && !bad_c;
                  state_q  <= req_write ? S_WRITE : S_READ;
               end
            end
            S_READ: begin
               if (err_q || (!fc_hi_c && timeout_c)) begin
                  rd_q    <= 1'b0;
                  valid_q <= 1'b1;
                  error_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_RESP;
               end else if (fc_hi_c) begin
                  rdata_q <= rdext_c;
                  rd_q    <= 1'b0;
                  valid_q <= 1'b1;
                  error_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WRITE: begin
               if (err_q || (!fc_hi_c && timeout_c)) begin
                  wr_q    <= 1'b0;
                  oe_q    <= 1'b0;
                  valid_q <= 1'b1;
                  error_q <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= S_RESP;
               end else if (fc_hi_c) begin
                  wr_q    <= 1'b0;
                  oe_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_RELEASE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RELEASE: begin
               if (!fc_hi_c || timeout_c) begin
                  valid_q <= 1'b1;
                  error_q <= fc_hi_c;
                  cnt_q   <= '0;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               addr_q  <= '0;
               mask_q  <= '0;
               err_q   <= 1'b0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: begin
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               oe_q    <= 1'b0;
               addr_q  <= '0;
               mask_q  <= '0;
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready     = ready_q;
   assign resp_valid    = valid_q;
   assign resp_error    = error_q;
   assign resp_rdata    = rdata_q;
   assign addr_bus      = addr_q;
   assign rd_bus        = rd_q;
   assign wr_bus        = wr_q;
   assign data_mask_bus = mask_q;
   assign data_bus      = oe_q ? wdata_q : {32{1'bz}};

endmodule

// File: tb/tb_bus_master_interface.sv
// Randomised scoreboard bench for bus_master_interface with a configurable responder
// that answers combinationally, answers one cycle late, or never answers.
module tb_bus_master_interface;

   localparam int unsigned T = 8;
   localparam int COMB = 0;
   localparam int REGD = 1;
   localparam int NONE = 2;

   logic        clk, rst;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata, addr_bus;
   wire  [31:0] data_bus;
   logic        rd_bus, wr_bus, fc_bus, fc_reg;
   logic [3:0]  data_mask_bus;

   int          mode;
   logic [31:0] rsp_data;

   bus_master_interface #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_signed(req_signed),
      .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
      .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
      .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Responder
   always @(posedge clk or posedge rst)
      if (rst) fc_reg <= 1'b0;
      else     fc_reg <= rd_bus | wr_bus;
   assign fc_bus   = (mode == COMB) ? (rd_bus | wr_bus) : (mode == REGD) ? fc_reg : 1'b0;
   assign data_bus = (rd_bus && mode != NONE) ? rsp_data : {32{1'bz}};

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      bit          err;
      logic [31:0] rdata;
      int          lat;
      int          strobes;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          pass_cnt = 0, total_cnt = 0;
   int          ncyc = 0, strobe_cnt = 0;
   logic [31:0] last_rdata = 32'h0;

   task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [3:0] ref_mask(input logic [1:0] sz);
      if (sz == 2'd0) return 4'h1;
      if (sz == 2'd1) return 4'h3;
      return 4'hF;
   endfunction

   function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] ref_extract(input logic [31:0] d, input logic [1:0] sz, input bit sg);
      longint v;
      if (sz == 2'd0) begin
         v = longint'(d % 256);
         if (sg && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = longint'(d % 65536);
         if (sg && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(d);
      end
      return 32'(v);
   endfunction

   // Monitor: bus-level checks every cycle, scoreboard pop on each response
   initial begin
      forever begin
         @(negedge clk);
         ncyc++;
         if (!rst) begin
            if (rd_bus || wr_bus) begin
               strobe_cnt++;
               chk("strobe_exclusive", !(rd_bus && wr_bus), 32'({rd_bus, wr_bus}), 32'h1);
               if (q.size() == 0) begin
                  chk("stray_strobe", 1'b0, 32'({rd_bus, wr_bus}), 32'h0);
               end else begin
                  chk("strobe_dir", wr_bus == q[0].wr, 32'(wr_bus), 32'(q[0].wr));
                  chk("addr_bus", addr_bus == q[0].addr, addr_bus, q[0].addr);
                  chk("mask", data_mask_bus == ref_mask(q[0].size), 32'(data_mask_bus), 32'(ref_mask(q[0].size)));
                  if (wr_bus) chk("data_bus_wr", data_bus == q[0].wdata, data_bus, q[0].wdata);
               end
            end
            if (req_ready) begin
               chk("idle_bus", addr_bus == 0 && data_mask_bus == 0 && !rd_bus && !wr_bus,
                   addr_bus | 32'(data_mask_bus) | 32'({rd_bus, wr_bus}), 32'h0);
            end
            if (resp_valid) begin
               if (q.size() == 0) begin
                  chk("unexpected_resp", 1'b0, 32'h1, 32'h0);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("resp_error", resp_error == e.err, 32'(resp_error), 32'(e.err));
                  chk("resp_rdata", resp_rdata == e.rdata, resp_rdata, e.rdata);
                  chk("resp_latency", (ncyc - e.acc) == e.lat, 32'(ncyc - e.acc), 32'(e.lat));
                  chk("strobe_cycles", strobe_cnt == e.strobes, 32'(strobe_cnt), 32'(e.strobes));
                  chk("no_strobe_in_resp", !rd_bus && !wr_bus, 32'({rd_bus, wr_bus}), 32'h0);
               end
            end
         end
      end
   end

   // Issue one request from the posedge+1 phase; optionally wiggle req_valid while busy.
   task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input bit sg, input int md,
                         input logic [31:0] rdat, input bit junk);
      int   guard;
      exp_t e;
      bit   bad, err;
      guard = 0;
      while (!req_ready && guard < 4 * int'(T) + 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) begin
         chk("ready_wait", 1'b0, 32'(req_ready), 32'h1);
         return;
      end
      mode       = md;
      rsp_data   = rdat;
      req_write  = wr;
      req_addr   = a;
      req_wdata  = wd;
      req_size   = sz;
      req_signed = sg;
      req_valid  = 1'b1;
      @(posedge clk); #1;
      bad = ref_bad(sz, a);
      err = bad || (md == NONE);
      e.wr    = wr;
      e.addr  = a;
      e.wdata = wd;
      e.size  = sz;
      e.err   = err;
      if (!wr && !err) last_rdata = ref_extract(rdat, sz, sg);
      e.rdata = last_rdata;
      if (bad)              begin e.lat = 2;          e.strobes = 0;      end
      else if (md == NONE)  begin e.lat = int'(T)+1;  e.strobes = int'(T); end
      else if (md == COMB)  begin e.lat = wr ? 3 : 2; e.strobes = 1;      end
      else                  begin e.lat = wr ? 5 : 3; e.strobes = 2;      end
      e.acc = ncyc;
      strobe_cnt = 0;
      q.push_back(e);
      chk("ready_drops", req_ready == 1'b0, 32'(req_ready), 32'h0);
      req_valid = junk;
      if (junk) begin
         req_write = $urandom_range(0, 1) != 0;
         req_addr  = $urandom;
         req_wdata = $urandom;
         req_size  = 2'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      req_size = '0; req_signed = 1'b0; mode = COMB; rsp_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", req_ready == 1'b1, 32'(req_ready), 32'h1);
      chk("rst_strobes", !rd_bus && !wr_bus, 32'({rd_bus, wr_bus}), 32'h0);
      chk("rst_addr_mask", addr_bus == 0 && data_mask_bus == 0, addr_bus | 32'(data_mask_bus), 32'h0);
      chk("rst_resp", !resp_valid && !resp_error && resp_rdata == 0, resp_rdata | 32'({resp_valid, resp_error}), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed scenarios
      do_txn(1'b0, 32'h0000_1000, 32'h0, 2'd2, 1'b0, COMB, 32'hDEAD_BEEF, 1'b0);
      do_txn(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b1, COMB, 32'h0000_0080, 1'b0);
      do_txn(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b0, COMB, 32'h0000_0080, 1'b0);
      do_txn(1'b1, 32'h0000_2002, 32'h0000_A5A5, 2'd1, 1'b0, REGD, 32'h0, 1'b0);
      do_txn(1'b0, 32'h0000_3002, 32'h0, 2'd2, 1'b0, COMB, 32'h1111_1111, 1'b0);
      do_txn(1'b0, 32'h0000_4000, 32'h0, 2'd2, 1'b0, NONE, 32'h0, 1'b0);
      do_txn(1'b0, 32'h0000_5001, 32'h0, 2'd1, 1'b1, COMB, 32'h0000_8001, 1'b0);
      do_txn(1'b0, 32'h0000_5002, 32'h0, 2'd1, 1'b1, REGD, 32'h0000_8001, 1'b1);
      do_txn(1'b1, 32'h0000_6000, 32'hCAFE_F00D, 2'd3, 1'b0, COMB, 32'h0, 1'b0);
      do_txn(1'b1, 32'h0000_7000, 32'h1234_5678, 2'd2, 1'b0, NONE, 32'h0, 1'b1);

      // Reset in the middle of a registered-responder write
      do_txn(1'b1, 32'h0000_2002, 32'h0000_A5A5, 2'd1, 1'b0, REGD, 32'h0, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_strobes", !wr_bus && !rd_bus, 32'({rd_bus, wr_bus}), 32'h0);
      chk("midrst_idle", req_ready && addr_bus == 0 && data_mask_bus == 0,
          addr_bus | 32'(data_mask_bus), 32'h0);
      chk("midrst_resp", !resp_valid && resp_rdata == 0, resp_rdata | 32'(resp_valid), 32'h0);
      q.delete();
      last_rdata = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_txn(1'b0, 32'h0000_5000, 32'h0, 2'd2, 1'b0, COMB, 32'h1234_5678, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         int          r, md;
         a  = $urandom;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
         r  = int'($urandom_range(0, 9));
         md = (r < 5) ? COMB : (r < 9) ? REGD : NONE;
         do_txn($urandom_range(0, 1) != 0, a, $urandom, sz, $urandom_range(0, 1) != 0,
                md, $urandom, $urandom_range(0, 2) == 0);
      end

      begin
         int guard;
         guard = 0;
         while ((q.size() != 0 || !req_ready) && guard < 4 * int'(T) + 20) begin
            @(posedge clk); #1;
            guard++;
         end
         chk("drain", q.size() == 0, 32'(q.size()), 32'h0);
      end
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
